// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: merges ALU and MEM writebacks onto one registered register-file write port.
// ALU traffic wins by default; a MEM FIFO head that keeps losing is force-granted after STARVE_LIMIT losses.
module cdb_arbiter #(
  parameter int MEM_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   WarpID_ALU_CDB,
  input  logic         RegWrite_ALU_CDB,
  input  logic [4:0]   Dst_ALU_CDB,
  input  logic [255:0] Dst_Data_ALU_CDB,
  input  logic [31:0]  Instr_ALU_CDB,
  input  logic [7:0]   ActiveMask_ALU_CDB,
  input  logic [2:0]   WarpID_MEM_CDB,
  input  logic         RegWrite_MEM_CDB,
  input  logic [4:0]   Dst_MEM_CDB,
  input  logic [255:0] Dst_Data_MEM_CDB,
  input  logic [31:0]  Instr_MEM_CDB,
  input  logic [7:0]   ActiveMask_MEM_CDB,
  output logic         Stall_CDB_ALU,
  output logic         Full_CDB_MEM,
  output logic [2:0]   HWWarp_CDB_RAU,
  output logic         RegWrite_CDB_RAU,
  output logic [2:0]   WriteAddr_CDB_RAU,
  output logic [255:0] Data_CDB_RAU,
  output logic [31:0]  Instr_CDB_RAU,
  output logic [7:0]   ActiveMask_CDB_RAU
);

  localparam int PW = $clog2(MEM_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int EW = 3 + 3 + 256 + 32 + 8;

  localparam logic [CW-1:0] FullCount = CW'(MEM_FIFO_DEPTH);
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_MEM  = 2'd1;
  localparam logic [1:0] SRC_HOLD = 2'd2;
  localparam logic [1:0] SRC_ALU  = 2'd3;

  // Entries are stored packed as {warp, writeAddr, data, instr, mask}; only Dst[2:0] is ever written out.
  logic [EW-1:0]   memStore_q [MEM_FIFO_DEPTH];
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starveCnt_q, starveCnt_d;
  logic            holdValid_q, holdValid_d;
  logic [EW-1:0]   holdEntry_q;

  logic [EW-1:0]   aluEntry;
  logic [EW-1:0]   memEntry;
  logic [EW-1:0]   grantEntry;
  logic            aluAccept;
  logic            memPush;
  logic            memValid;
  logic            memForce;
  logic            memPop;
  logic            holdCapture;
  logic [1:0]      grantSrc;
  logic            unusedDstBits;

  assign aluEntry = {WarpID_ALU_CDB, Dst_ALU_CDB[2:0], Dst_Data_ALU_CDB,
                     Instr_ALU_CDB, ActiveMask_ALU_CDB};
  assign memEntry = {WarpID_MEM_CDB, Dst_MEM_CDB[2:0], Dst_Data_MEM_CDB,
                     Instr_MEM_CDB, ActiveMask_MEM_CDB};
  assign unusedDstBits = ^{Dst_ALU_CDB[4:3], Dst_MEM_CDB[4:3]};

  assign Stall_CDB_ALU = holdValid_q;
  assign Full_CDB_MEM  = (count_q == FullCount);

  assign aluAccept = RegWrite_ALU_CDB & ~holdValid_q;
  assign memPush   = RegWrite_MEM_CDB & ~Full_CDB_MEM;
  assign memValid  = (count_q != '0);
  assign memForce  = memValid & (starveCnt_q == StarveMax);

  // A starved MEM head beats everything; otherwise held ALU, fresh ALU, then MEM.
  always_comb begin
    grantSrc = SRC_NONE;
    if (memForce) begin
      grantSrc = SRC_MEM;
    end else if (holdValid_q) begin
      grantSrc = SRC_HOLD;
    end else if (aluAccept) begin
      grantSrc = SRC_ALU;
    end else if (memValid) begin
      grantSrc = SRC_MEM;
    end
  end

  always_comb begin
    grantEntry = '0;
    case (grantSrc)
      SRC_MEM:  grantEntry = memStore_q[rdPtr_q];
      SRC_HOLD: grantEntry = holdEntry_q;
      SRC_ALU:  grantEntry = aluEntry;
      default:  grantEntry = '0;
    endcase
  end

  assign memPop      = (grantSrc == SRC_MEM);
  assign holdCapture = memPop & aluAccept;

  always_comb begin
    rdPtr_d     = memPop  ? rdPtr_q + 1'b1 : rdPtr_q;
    wrPtr_d     = memPush ? wrPtr_q + 1'b1 : wrPtr_q;
    count_d     = count_q + CW'(memPush) - CW'(memPop);
    holdValid_d = holdValid_q;
    if (grantSrc == SRC_HOLD) begin
      holdValid_d = 1'b0;
    end else if (holdCapture) begin
      holdValid_d = 1'b1;
    end
    starveCnt_d = starveCnt_q;
    if (!memValid || memPop) begin
      starveCnt_d = '0;
    end else if (starveCnt_q != StarveMax) begin
      starveCnt_d = starveCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q            <= '0;
      wrPtr_q            <= '0;
      count_q            <= '0;
      starveCnt_q        <= '0;
      holdValid_q        <= 1'b0;
      RegWrite_CDB_RAU   <= 1'b0;
      HWWarp_CDB_RAU     <= '0;
      WriteAddr_CDB_RAU  <= '0;
      Data_CDB_RAU       <= '0;
      Instr_CDB_RAU      <= '0;
      ActiveMask_CDB_RAU <= '0;
    end else begin
      rdPtr_q          <= rdPtr_d;
      wrPtr_q          <= wrPtr_d;
      count_q          <= count_d;
      starveCnt_q      <= starveCnt_d;
      holdValid_q      <= holdValid_d;
      RegWrite_CDB_RAU <= (grantSrc != SRC_NONE);
      if (grantSrc != SRC_NONE) begin
        {HWWarp_CDB_RAU, WriteAddr_CDB_RAU, Data_CDB_RAU,
         Instr_CDB_RAU, ActiveMask_CDB_RAU} <= grantEntry;
      end
    end
  end

  // Payload storage needs no reset: validity is tracked entirely by count_q and holdValid_q.
  always_ff @(posedge clk) begin
    if (!rst && memPush) begin
      memStore_q[wrPtr_q] <= memEntry;
    end
    if (!rst && holdCapture) begin
      holdEntry_q <= aluEntry;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a queue-based reference model.
module tb_cdb_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 3;

  logic         clk;
  logic         rst;
  logic [2:0]   WarpID_ALU_CDB, WarpID_MEM_CDB;
  logic         RegWrite_ALU_CDB, RegWrite_MEM_CDB;
  logic [4:0]   Dst_ALU_CDB, Dst_MEM_CDB;
  logic [255:0] Dst_Data_ALU_CDB, Dst_Data_MEM_CDB;
  logic [31:0]  Instr_ALU_CDB, Instr_MEM_CDB;
  logic [7:0]   ActiveMask_ALU_CDB, ActiveMask_MEM_CDB;
  logic         Stall_CDB_ALU, Full_CDB_MEM;
  logic [2:0]   HWWarp_CDB_RAU;
  logic         RegWrite_CDB_RAU;
  logic [2:0]   WriteAddr_CDB_RAU;
  logic [255:0] Data_CDB_RAU;
  logic [31:0]  Instr_CDB_RAU;
  logic [7:0]   ActiveMask_CDB_RAU;

  cdb_arbiter #(.MEM_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .WarpID_ALU_CDB(WarpID_ALU_CDB), .RegWrite_ALU_CDB(RegWrite_ALU_CDB),
    .Dst_ALU_CDB(Dst_ALU_CDB), .Dst_Data_ALU_CDB(Dst_Data_ALU_CDB),
    .Instr_ALU_CDB(Instr_ALU_CDB), .ActiveMask_ALU_CDB(ActiveMask_ALU_CDB),
    .WarpID_MEM_CDB(WarpID_MEM_CDB), .RegWrite_MEM_CDB(RegWrite_MEM_CDB),
    .Dst_MEM_CDB(Dst_MEM_CDB), .Dst_Data_MEM_CDB(Dst_Data_MEM_CDB),
    .Instr_MEM_CDB(Instr_MEM_CDB), .ActiveMask_MEM_CDB(ActiveMask_MEM_CDB),
    .Stall_CDB_ALU(Stall_CDB_ALU), .Full_CDB_MEM(Full_CDB_MEM),
    .HWWarp_CDB_RAU(HWWarp_CDB_RAU), .RegWrite_CDB_RAU(RegWrite_CDB_RAU),
    .WriteAddr_CDB_RAU(WriteAddr_CDB_RAU), .Data_CDB_RAU(Data_CDB_RAU),
    .Instr_CDB_RAU(Instr_CDB_RAU), .ActiveMask_CDB_RAU(ActiveMask_CDB_RAU)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   warp;
    logic [4:0]   dst;
    logic [255:0] data;
    logic [31:0]  instr;
    logic [7:0]   mask;
  } entry_t;

  int     checks = 0;
  int     failures = 0;
  bit     modelOn = 1'b0;
  entry_t memQ[$];
  bit     mHoldValid = 1'b0;
  entry_t mHold;
  int     mStarve = 0;
  bit     expValid = 1'b0;
  entry_t expOut = '{default: '0};
  logic [255:0] memSeen[$];

  task automatic checkVal(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference model: one writeback per cycle chosen by the priority rules, MEM kept as a queue.
  always @(posedge clk) begin : model
    entry_t aluIn, memIn;
    bit aluTaken, memTaken, headReady, memWon;
    if (rst) begin
      memQ.delete();
      mHoldValid = 1'b0;
      mStarve    = 0;
      expValid   = 1'b0;
      expOut     = '{default: '0};
    end else begin
      aluIn = '{WarpID_ALU_CDB, Dst_ALU_CDB, Dst_Data_ALU_CDB, Instr_ALU_CDB, ActiveMask_ALU_CDB};
      memIn = '{WarpID_MEM_CDB, Dst_MEM_CDB, Dst_Data_MEM_CDB, Instr_MEM_CDB, ActiveMask_MEM_CDB};
      aluTaken  = RegWrite_ALU_CDB && !mHoldValid;
      memTaken  = RegWrite_MEM_CDB && (memQ.size() < DEPTH);
      headReady = memQ.size() > 0;
      memWon    = 1'b0;
      expValid  = 1'b1;
      if (headReady && mStarve == LIMIT) begin
        expOut = memQ.pop_front();
        memWon = 1'b1;
        if (aluTaken) begin
          mHoldValid = 1'b1;
          mHold      = aluIn;
        end
      end else if (mHoldValid) begin
        expOut     = mHold;
        mHoldValid = 1'b0;
      end else if (aluTaken) begin
        expOut = aluIn;
      end else if (headReady) begin
        expOut = memQ.pop_front();
        memWon = 1'b1;
      end else begin
        expValid = 1'b0;
      end
      if (!headReady || memWon) mStarve = 0;
      else if (mStarve < LIMIT) mStarve++;
      if (memTaken) memQ.push_back(memIn);
    end
  end

  task automatic checkOutput();
    checkVal("regwrite", 256'(RegWrite_CDB_RAU), 256'(expValid));
    checkVal("hwwarp", 256'(HWWarp_CDB_RAU), 256'(expOut.warp));
    checkVal("writeaddr", 256'(WriteAddr_CDB_RAU), 256'(expOut.dst[2:0]));
    checkVal("data", Data_CDB_RAU, expOut.data);
    checkVal("instr", 256'(Instr_CDB_RAU), 256'(expOut.instr));
    checkVal("mask", 256'(ActiveMask_CDB_RAU), 256'(expOut.mask));
    checkVal("stall", 256'(Stall_CDB_ALU), 256'(mHoldValid));
    checkVal("full", 256'(Full_CDB_MEM), 256'(memQ.size() == DEPTH));
  endtask

  always @(negedge clk) begin
    if (modelOn) checkOutput();
  end

  task automatic applyStimulus(input logic aluReq, input logic [2:0] aluWarp,
                               input logic [4:0] aluDst, input logic [255:0] aluData,
                               input logic memReq, input logic [2:0] memWarp,
                               input logic [4:0] memDst, input logic [255:0] memData);
    RegWrite_ALU_CDB   = aluReq;
    WarpID_ALU_CDB     = aluWarp;
    Dst_ALU_CDB        = aluDst;
    Dst_Data_ALU_CDB   = aluData;
    Instr_ALU_CDB      = $urandom();
    ActiveMask_ALU_CDB = 8'($urandom_range(0, 255));
    RegWrite_MEM_CDB   = memReq;
    WarpID_MEM_CDB     = memWarp;
    Dst_MEM_CDB        = memDst;
    Dst_Data_MEM_CDB   = memData;
    Instr_MEM_CDB      = $urandom();
    ActiveMask_MEM_CDB = 8'($urandom_range(0, 255));
  endtask

  task automatic idle();
    applyStimulus(1'b0, 3'd0, 5'd0, '0, 1'b0, 3'd0, 5'd0, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic collectMem();
    if (RegWrite_CDB_RAU === 1'b1 && Data_CDB_RAU[15:12] == 4'h3) memSeen.push_back(Data_CDB_RAU);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) tick();
    modelOn = 1'b1;
    checkVal("reset_regwrite", 256'(RegWrite_CDB_RAU), 256'(0));
    checkVal("reset_data", Data_CDB_RAU, 256'(0));
    checkVal("reset_stall", 256'(Stall_CDB_ALU), 256'(0));
    checkVal("reset_full", 256'(Full_CDB_MEM), 256'(0));
    rst = 1'b0;

    applyStimulus(1'b1, 3'd5, 5'h1A, {32{8'hA5}}, 1'b0, 3'd0, 5'd0, '0);
    tick();
    checkVal("alu_only_valid", 256'(RegWrite_CDB_RAU), 256'(1));
    checkVal("alu_only_warp", 256'(HWWarp_CDB_RAU), 256'(5));
    checkVal("alu_only_addr", 256'(WriteAddr_CDB_RAU), 256'(2));
    checkVal("alu_only_data", Data_CDB_RAU, {32{8'hA5}});
    idle();
    tick();
    checkVal("alu_only_idle", 256'(RegWrite_CDB_RAU), 256'(0));
    checkVal("alu_only_hold_data", Data_CDB_RAU, {32{8'hA5}});

    applyStimulus(1'b1, 3'd1, 5'h03, 256'h111, 1'b1, 3'd2, 5'h04, 256'h222);
    tick();
    checkVal("both_alu_data", Data_CDB_RAU, 256'h111);
    idle();
    tick();
    checkVal("both_mem_valid", 256'(RegWrite_CDB_RAU), 256'(1));
    checkVal("both_mem_data", Data_CDB_RAU, 256'h222);
    checkVal("both_mem_addr", 256'(WriteAddr_CDB_RAU), 256'(4));
    tick();
    checkVal("both_drained", 256'(RegWrite_CDB_RAU), 256'(0));

    for (int t = 0; t <= 5; t++) begin
      applyStimulus(1'b1, 3'(t), 5'(t), 256'(16'h1000 + t), t == 0, 3'd7, 5'h07, 256'h5EED);
      tick();
      if (t <= 3) checkVal("starve_alu_data", Data_CDB_RAU, 256'(16'h1000 + t));
      if (t == 4) begin
        checkVal("starve_mem_forced", Data_CDB_RAU, 256'h5EED);
        checkVal("starve_stall_set", 256'(Stall_CDB_ALU), 256'(1));
      end
      if (t == 5) begin
        checkVal("starve_held_data", Data_CDB_RAU, 256'h1004);
        checkVal("starve_stall_clr", 256'(Stall_CDB_ALU), 256'(0));
      end
    end
    idle();
    tick();
    checkVal("starve_discarded", 256'(RegWrite_CDB_RAU), 256'(0));

    memSeen.delete();
    for (int t = 0; t < 12; t++) begin
      applyStimulus(1'b1, 3'd1, 5'd1, 256'(16'h2000 + t), t < 5, 3'(t), 5'(t), 256'(16'h3000 + t));
      tick();
      collectMem();
      if (t == 3) checkVal("full_after_4", 256'(Full_CDB_MEM), 256'(1));
      if (t == 4) checkVal("full_after_pop", 256'(Full_CDB_MEM), 256'(0));
    end
    idle();
    for (int t = 0; t < 12; t++) begin
      tick();
      collectMem();
    end
    checkVal("full_mem_count", 256'(memSeen.size()), 256'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < memSeen.size()) checkVal("full_mem_order", memSeen[i], 256'(16'h3000 + i));
    end

    memSeen.delete();
    for (int t = 0; t < 4; t++) begin
      applyStimulus(1'b0, 3'd0, 5'd0, '0, 1'b1, 3'(t), 5'(t), 256'(16'h3100 + t));
      tick();
      collectMem();
    end
    idle();
    for (int t = 0; t < 6; t++) begin
      tick();
      collectMem();
    end
    checkVal("wrap_count", 256'(memSeen.size()), 256'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < memSeen.size()) checkVal("wrap_order", memSeen[i], 256'(16'h3100 + i));
    end

    for (int t = 0; t <= 4; t++) begin
      applyStimulus(1'b1, 3'd2, 5'd2, 256'(16'h5000 + t), t != 3, 3'd3, 5'd3, 256'(16'h6000 + t));
      tick();
    end
    checkVal("pre_reset_stall", 256'(Stall_CDB_ALU), 256'(1));
    checkVal("pre_reset_full", 256'(Full_CDB_MEM), 256'(0));
    rst = 1'b1;
    applyStimulus(1'b1, 3'd6, 5'd6, 256'h7777, 1'b1, 3'd6, 5'd6, 256'h8888);
    tick();
    checkVal("midrst_regwrite", 256'(RegWrite_CDB_RAU), 256'(0));
    checkVal("midrst_data", Data_CDB_RAU, 256'(0));
    checkVal("midrst_warp", 256'(HWWarp_CDB_RAU), 256'(0));
    checkVal("midrst_stall", 256'(Stall_CDB_ALU), 256'(0));
    checkVal("midrst_full", 256'(Full_CDB_MEM), 256'(0));
    rst = 1'b0;
    idle();
    for (int t = 0; t < 6; t++) begin
      tick();
      checkVal("midrst_no_stale", 256'(RegWrite_CDB_RAU), 256'(0));
    end

    for (int t = 0; t < 3000; t++) begin
      applyStimulus($urandom_range(0, 99) < 60, 3'($urandom()), 5'($urandom()), rand256(),
                    $urandom_range(0, 99) < 45, 3'($urandom()), 5'($urandom()), rand256());
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
